// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: mnemonics, opcodes,
// register ids, funct3/funct7 constants and immediate range limits.
package rv32i_instr_encoder_pkg;

    typedef enum logic [5:0] {
        NULL,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
        SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU,
        XOR, SRL, SRA, OR, AND,
        ECALL, EBREAK,
        MUL
    } RV32I_INSTRUCTION_MNEMONIC_t;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_IMM    = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } RV32I_OPCODE_t;

    typedef logic [4:0] RV32I_REGISTER_t;

    // Encoding layout selected by the mnemonic decode.
    typedef enum logic [3:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SYS
    } enc_fmt_t;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [2:0] F3_BYTE    = 3'b000;
    localparam logic [2:0] F3_HALF    = 3'b001;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BYTE_U  = 3'b100;
    localparam logic [2:0] F3_HALF_U  = 3'b101;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam int I_IMM_MIN = -2048;
    localparam int I_IMM_MAX = 2047;
    localparam int B_IMM_MIN = -4096;
    localparam int B_IMM_MAX = 4094;
    localparam int J_IMM_MIN = -(1 << 20);
    localparam int J_IMM_MAX = (1 << 20) - 2;

    function automatic logic imm_in_range(
        input logic [31:0] imm,
        input int          lo,
        input int          hi
    );
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/rv32i_encode_comb.sv
// Combinational RV32I encoder: {mnemonic, rd, rs1, rs2, imm} -> {word, illegal}.
// Ports: mnemonic/rd/rs1/rs2/imm in; word, illegal out. MUL needs RV32I_ENC_RV32M_EN.
module rv32i_encode_comb
    import rv32i_instr_encoder_pkg::*;
(
    input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
    input  RV32I_REGISTER_t             rd,
    input  RV32I_REGISTER_t             rs1,
    input  RV32I_REGISTER_t             rs2,
    input  logic [31:0]                 imm,
    output logic [31:0]                 word,
    output logic                        illegal
);

    enc_fmt_t      fmt;
    RV32I_OPCODE_t opc;
    logic [2:0]    f3;
    logic [6:0]    f7;

    always_comb begin
        fmt = FMT_NONE;
        opc = OPC_OP;
        f3  = F3_ADD_SUB;
        f7  = F7_BASE;
        unique case (mnemonic)
            LUI:    begin fmt = FMT_U; opc = OPC_LUI;   end
            AUIPC:  begin fmt = FMT_U; opc = OPC_AUIPC; end
            JAL:    begin fmt = FMT_J; opc = OPC_JAL;   end
            JALR:   begin fmt = FMT_I; opc = OPC_JALR;  end
            BEQ:    begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ;  end
            BNE:    begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE;  end
            BLT:    begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT;  end
            BGE:    begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE;  end
            BLTU:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
            BGEU:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
            LB:     begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BYTE;   end
            LH:     begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HALF;   end
            LW:     begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_WORD;   end
            LBU:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BYTE_U; end
            LHU:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HALF_U; end
            SB:     begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_BYTE; end
            SH:     begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_HALF; end
            SW:     begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_WORD; end
            ADDI:   begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_ADD_SUB; end
            SLTI:   begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_SLT;     end
            SLTIU:  begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_SLTU;    end
            XORI:   begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_XOR;     end
            ORI:    begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_OR;      end
            ANDI:   begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_AND;     end
            SLLI:   begin fmt = FMT_SH; opc = OPC_IMM; f3 = F3_SLL; end
            SRLI:   begin fmt = FMT_SH; opc = OPC_IMM; f3 = F3_SRL_SRA; end
            SRAI: begin
                fmt = FMT_SH;
                opc = OPC_IMM;
                f3  = F3_SRL_SRA;
                f7  = F7_ALT;
            end
            ADD:    begin fmt = FMT_R; f3 = F3_ADD_SUB; end
            SUB:    begin fmt = FMT_R; f3 = F3_ADD_SUB; f7 = F7_ALT; end
            SLL:    begin fmt = FMT_R; f3 = F3_SLL;  end
            SLT:    begin fmt = FMT_R; f3 = F3_SLT;  end
            SLTU:   begin fmt = FMT_R; f3 = F3_SLTU; end
            XOR:    begin fmt = FMT_R; f3 = F3_XOR;  end
            SRL:    begin fmt = FMT_R; f3 = F3_SRL_SRA; end
            SRA:    begin fmt = FMT_R; f3 = F3_SRL_SRA; f7 = F7_ALT; end
            OR:     begin fmt = FMT_R; f3 = F3_OR;   end
            AND:    begin fmt = FMT_R; f3 = F3_AND;  end
            ECALL:  begin fmt = FMT_SYS; opc = OPC_SYSTEM; end
            EBREAK: begin fmt = FMT_SYS; opc = OPC_SYSTEM; end
            MUL: begin
`ifdef RV32I_ENC_RV32M_EN
                fmt = FMT_R;
                f7  = F7_MULDIV;
`else
                fmt = FMT_NONE;
`endif
            end
            default: fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        unique case (fmt)
            FMT_R: word = {f7, rs2, rs1, f3, rd, opc};
            FMT_I: begin
                word    = {imm[11:0], rs1, f3, rd, opc};
                illegal = !imm_in_range(imm, I_IMM_MIN, I_IMM_MAX);
            end
            FMT_SH: begin
                word    = {f7, imm[4:0], rs1, f3, rd, opc};
                illegal = |imm[31:5];
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                illegal = !imm_in_range(imm, I_IMM_MIN, I_IMM_MAX);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3,
                        imm[4:1], imm[11], opc};
                illegal = imm[0] ||
                          !imm_in_range(imm, B_IMM_MIN, B_IMM_MAX);
            end
            FMT_U: begin
                word    = {imm[31:12], rd, opc};
                illegal = |imm[11:0];
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12],
                        rd, opc};
                illegal = imm[0] ||
                          !imm_in_range(imm, J_IMM_MIN, J_IMM_MAX);
            end
            // Operand fields are ignored: only imm bit 20 differs.
            FMT_SYS: word = {11'd0, (mnemonic == EBREAK), 13'd0, opc};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I encoder front: accepts encode requests, writes words to IMEM at an
// auto-incrementing address. Ports: clk, rst_n, clear_i, req_* (valid/ready
// + fields), wr_* (valid/ready/addr/data), count_o, full_o, err_o.
// MUL support is enabled by defining RV32I_ENC_RV32M_EN.
module rv32i_instr_encoder
    import rv32i_instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  RV32I_INSTRUCTION_MNEMONIC_t req_mnemonic_i,
    input  RV32I_REGISTER_t             req_rd_i,
    input  RV32I_REGISTER_t             req_rs1_i,
    input  RV32I_REGISTER_t             req_rs2_i,
    input  logic [31:0]                 req_imm_i,
    output logic                        wr_valid_o,
    input  logic                        wr_ready_i,
    output logic [ADDR_W-1:0]           wr_addr_o,
    output logic [31:0]                 wr_data_o,
    output logic [ADDR_W:0]             count_o,
    output logic                        full_o,
    output logic                        err_o
);

    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              wr_valid_q;
    logic [31:0]       wr_data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic [ADDR_W+1:0] in_flight;
    logic              wr_fire;
    logic              req_fire;

    rv32i_encode_comb u_enc (
        .mnemonic (req_mnemonic_i),
        .rd       (req_rd_i),
        .rs1      (req_rs1_i),
        .rs2      (req_rs2_i),
        .imm      (req_imm_i),
        .word     (enc_word),
        .illegal  (enc_illegal)
    );

    // Words already written plus the one waiting in the output register.
    assign in_flight = {1'b0, count_q}
                     + {{(ADDR_W+1){1'b0}}, wr_valid_q};

    assign wr_fire     = wr_valid_q && wr_ready_i;
    assign req_ready_o = !clear_i
                      && (in_flight < DEPTH_X)
                      && (!wr_valid_q || wr_ready_i);
    assign req_fire    = req_valid_i && req_ready_o;

    // addr_q is the address of the pending (or next) write; it only
    // moves on a completed write, so dropped requests leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else if (clear_i) begin
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (wr_fire) begin
                addr_q  <= (addr_q == LAST_A) ? '0
                         : addr_q + ADDR_W'(1);
                count_q <= count_q + (ADDR_W+1)'(1);
            end
            if (req_fire) begin
                wr_valid_q <= !enc_illegal;
                if (!enc_illegal) begin
                    wr_data_q <= enc_word;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (wr_fire) begin
                wr_valid_q <= 1'b0;
            end
        end
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_data_o  = wr_data_q;
    assign wr_addr_o  = addr_q;
    assign count_o    = count_q;
    assign full_o     = (count_q == DEPTH_C);
    assign err_o      = err_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: field-arithmetic reference encoder,
// queue scoreboard checked every cycle, plus directed literal vectors.
module tb_rv32i_instr_encoder;
    import rv32i_instr_encoder_pkg::*;

    localparam int AW = 3;
    localparam int DP = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_i = 1'b0;
    logic req_valid_i = 1'b0;
    logic req_ready_o;
    RV32I_INSTRUCTION_MNEMONIC_t req_mnemonic_i = NULL;
    RV32I_REGISTER_t req_rd_i = '0;
    RV32I_REGISTER_t req_rs1_i = '0;
    RV32I_REGISTER_t req_rs2_i = '0;
    logic [31:0] req_imm_i = '0;
    logic wr_valid_o;
    logic wr_ready_i = 1'b1;
    logic [AW-1:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [AW:0] count_o;
    logic full_o;
    logic err_o;

    rv32i_instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (clear_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_mnemonic_i (req_mnemonic_i),
        .req_rd_i       (req_rd_i),
        .req_rs1_i      (req_rs1_i),
        .req_rs2_i      (req_rs2_i),
        .req_imm_i      (req_imm_i),
        .wr_valid_o     (wr_valid_o),
        .wr_ready_i     (wr_ready_i),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int send_cycles = 0;

    task automatic chk(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef enum {K_X, K_R, K_I, K_H, K_S, K_B, K_U, K_J, K_E} kind_t;

    function automatic longint p2(input int n);
        return longint'(1) << n;
    endfunction

    // Reference encoder: returns {legal, word} from field arithmetic.
    function automatic logic [32:0] ref_enc(
        input RV32I_INSTRUCTION_MNEMONIC_t mn,
        input int rd, input int rs1, input int rs2, input int imm);
        kind_t k;
        int op, f3, f7;
        longint u, w, base;
        bit ok;
        k = K_X; op = 0; f3 = 0; f7 = 0; ok = 1'b1; w = 0;
        u = longint'(imm) & 64'h0000_0000_FFFF_FFFF;
        case (mn)
            LUI:    begin k = K_U; op = 'h37; end
            AUIPC:  begin k = K_U; op = 'h17; end
            JAL:    begin k = K_J; op = 'h6F; end
            JALR:   begin k = K_I; op = 'h67; end
            BEQ:    begin k = K_B; op = 'h63; f3 = 0; end
            BNE:    begin k = K_B; op = 'h63; f3 = 1; end
            BLT:    begin k = K_B; op = 'h63; f3 = 4; end
            BGE:    begin k = K_B; op = 'h63; f3 = 5; end
            BLTU:   begin k = K_B; op = 'h63; f3 = 6; end
            BGEU:   begin k = K_B; op = 'h63; f3 = 7; end
            LB:     begin k = K_I; op = 'h03; f3 = 0; end
            LH:     begin k = K_I; op = 'h03; f3 = 1; end
            LW:     begin k = K_I; op = 'h03; f3 = 2; end
            LBU:    begin k = K_I; op = 'h03; f3 = 4; end
            LHU:    begin k = K_I; op = 'h03; f3 = 5; end
            SB:     begin k = K_S; op = 'h23; f3 = 0; end
            SH:     begin k = K_S; op = 'h23; f3 = 1; end
            SW:     begin k = K_S; op = 'h23; f3 = 2; end
            ADDI:   begin k = K_I; op = 'h13; f3 = 0; end
            SLTI:   begin k = K_I; op = 'h13; f3 = 2; end
            SLTIU:  begin k = K_I; op = 'h13; f3 = 3; end
            XORI:   begin k = K_I; op = 'h13; f3 = 4; end
            ORI:    begin k = K_I; op = 'h13; f3 = 6; end
            ANDI:   begin k = K_I; op = 'h13; f3 = 7; end
            SLLI:   begin k = K_H; op = 'h13; f3 = 1; end
            SRLI:   begin k = K_H; op = 'h13; f3 = 5; end
            SRAI:   begin k = K_H; op = 'h13; f3 = 5; f7 = 32; end
            ADD:    begin k = K_R; op = 'h33; f3 = 0; end
            SUB:    begin k = K_R; op = 'h33; f3 = 0; f7 = 32; end
            SLL:    begin k = K_R; op = 'h33; f3 = 1; end
            SLT:    begin k = K_R; op = 'h33; f3 = 2; end
            SLTU:   begin k = K_R; op = 'h33; f3 = 3; end
            XOR:    begin k = K_R; op = 'h33; f3 = 4; end
            SRL:    begin k = K_R; op = 'h33; f3 = 5; end
            SRA:    begin k = K_R; op = 'h33; f3 = 5; f7 = 32; end
            OR:     begin k = K_R; op = 'h33; f3 = 6; end
            AND:    begin k = K_R; op = 'h33; f3 = 7; end
`ifdef RV32I_ENC_RV32M_EN
            MUL:    begin k = K_R; op = 'h33; f3 = 0; f7 = 1; end
`endif
            ECALL:  k = K_E;
            EBREAK: k = K_E;
            default: k = K_X;
        endcase
        base = op + rd * p2(7) + f3 * p2(12) + rs1 * p2(15);
        case (k)
            K_R: w = base + rs2 * p2(20) + f7 * p2(25);
            K_I: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w = base + (u % 4096) * p2(20);
            end
            K_H: begin
                ok = (imm >= 0) && (imm < 32);
                w = base + (u % 32) * p2(20) + f7 * p2(25);
            end
            K_S: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w = op + f3 * p2(12) + rs1 * p2(15) + rs2 * p2(20)
                  + (u % 32) * p2(7) + ((u / 32) % 128) * p2(25);
            end
            K_B: begin
                ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
                w = op + f3 * p2(12) + rs1 * p2(15) + rs2 * p2(20)
                  + ((u / 2048) % 2) * p2(7) + ((u / 2) % 16) * p2(8)
                  + ((u / 32) % 64) * p2(25) + ((u / 4096) % 2) * p2(31);
            end
            K_U: begin
                ok = (u % 4096 == 0);
                w = u - (u % 4096) + rd * p2(7) + op;
            end
            K_J: begin
                ok = (imm >= -(1 << 20)) && (imm <= (1 << 20) - 2)
                  && (imm % 2 == 0);
                w = op + rd * p2(7) + ((u / 4096) % 256) * p2(12)
                  + ((u / 2048) % 2) * p2(20) + ((u / 2) % 1024) * p2(21)
                  + ((u / p2(20)) % 2) * p2(31);
            end
            K_E: w = 'h73 + ((mn == EBREAK) ? p2(20) : 0);
            default: ok = 1'b0;
        endcase
        return {ok, w[31:0]};
    endfunction

    // Scoreboard state.
    logic [31:0] m_q[$];
    int m_addr = 0;
    int m_count = 0;
    bit m_err = 1'b0;

    always @(negedge clk) begin
        bit exp_rdy;
        bit pend;
        logic [32:0] r;
        if (!rst_n) begin
            m_q.delete();
            m_addr = 0;
            m_count = 0;
            m_err = 1'b0;
        end
        pend = (m_q.size() != 0);
        exp_rdy = !clear_i && (m_count + int'(pend) < DP)
               && (!pend || wr_ready_i);
        chk("wr_valid", 33'(wr_valid_o), 33'(pend));
        if (pend) begin
            chk("wr_data", 33'(wr_data_o), {1'b0, m_q[0]});
            chk("wr_addr", 33'(wr_addr_o), 33'(m_addr));
        end else if (!rst_n) begin
            chk("rst_data", 33'(wr_data_o), 33'(0));
            chk("rst_addr", 33'(wr_addr_o), 33'(0));
        end
        chk("count", 33'(count_o), 33'(m_count));
        chk("full", 33'(full_o), 33'(m_count == DP));
        chk("err", 33'(err_o), 33'(m_err));
        chk("req_ready", 33'(req_ready_o), 33'(exp_rdy));
        if (rst_n) begin
            if (clear_i) begin
                m_q.delete();
                m_addr = 0;
                m_count = 0;
                m_err = 1'b0;
            end else begin
                if (pend && wr_ready_i) begin
                    void'(m_q.pop_front());
                    m_addr = (m_addr + 1) % DP;
                    m_count++;
                end
                if (req_valid_i && exp_rdy) begin
                    r = ref_enc(req_mnemonic_i, int'(req_rd_i),
                                int'(req_rs1_i), int'(req_rs2_i),
                                int'(req_imm_i));
                    if (r[32]) m_q.push_back(r[31:0]);
                    else m_err = 1'b1;
                end
            end
        end
    end

    task automatic set_req(input RV32I_INSTRUCTION_MNEMONIC_t mn,
                           input int rd, input int rs1, input int rs2,
                           input int imm);
        req_valid_i = 1'b1;
        req_mnemonic_i = mn;
        req_rd_i = 5'(rd);
        req_rs1_i = 5'(rs1);
        req_rs2_i = 5'(rs2);
        req_imm_i = imm;
    endtask

    task automatic send(input RV32I_INSTRUCTION_MNEMONIC_t mn,
                        input int rd, input int rs1, input int rs2,
                        input int imm);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        set_req(mn, rd, rs1, rs2, imm);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = req_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        send_cycles += n;
        req_valid_i = 1'b0;
        chk("accept", 33'(acc), 33'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    task automatic pin(input string name,
                       input RV32I_INSTRUCTION_MNEMONIC_t mn,
                       input int rd, input int rs1, input int rs2,
                       input int imm, input logic [32:0] exp);
        chk(name, ref_enc(mn, rd, rs1, rs2, imm), exp);
    endtask

    RV32I_INSTRUCTION_MNEMONIC_t vm[22] = '{
        ADDI, SW, SW, BEQ, BNE, BLT, JAL, JAL, JAL, JAL, JALR,
        LUI, AUIPC, SLLI, SLLI, SRLI, NULL,
        RV32I_INSTRUCTION_MNEMONIC_t'(6'h3F),
        ECALL, EBREAK, LHU, SUB};
    int vi[22] = '{
        -2048, 2047, -2049, 4094, -4096, 4096,
        -1048576, 1048574, 1048576, 5, 2047,
        'h800, -4096, 31, 32, -1, 0, 0, 0, 0, -1, 0};

    initial begin
        int c0;
        pin("pin_addi", ADDI, 1, 0, 0, 5, {1'b1, 32'h00500093});
        pin("pin_add", ADD, 3, 1, 2, 0, {1'b1, 32'h002081B3});
        pin("pin_sw", SW, 0, 1, 2, 8, {1'b1, 32'h0020A423});
        pin("pin_beq", BEQ, 0, 1, 2, -4, {1'b1, 32'hFE208EE3});
        pin("pin_jal", JAL, 1, 0, 0, 2048, {1'b1, 32'h001000EF});
        pin("pin_lui", LUI, 5, 0, 0, 'h12345000, {1'b1, 32'h123452B7});
        pin("pin_srai", SRAI, 1, 2, 0, 7, {1'b1, 32'h40715093});
        pin("pin_ecall", ECALL, 0, 0, 0, 0, {1'b1, 32'h00000073});
        pin("pin_ebreak", EBREAK, 0, 0, 0, 0, {1'b1, 32'h00100073});
        chk("pin_addi_ill", 33'(ref_enc(ADDI, 1, 0, 0, 2048) >> 32), 33'(0));
        chk("pin_beq_ill", 33'(ref_enc(BEQ, 0, 1, 2, 3) >> 32), 33'(0));
`ifdef RV32I_ENC_RV32M_EN
        pin("pin_mul", MUL, 3, 1, 2, 0, {1'b1, 32'h022081B3});
`else
        chk("pin_mul_ill", 33'(ref_enc(MUL, 3, 1, 2, 0) >> 32), 33'(0));
`endif

        // Reset.
        #22;
        rst_n = 1'b1;
        idle(1);
        chk("rst_count", 33'(count_o), 33'(0));
        chk("rst_valid", 33'(wr_valid_o), 33'(0));

        // ADDI, one-cycle latency.
        send(ADDI, 1, 0, 0, 5);
        @(negedge clk);
        chk("t1_data", 33'(wr_data_o), 33'(32'h00500093));
        chk("t1_addr", 33'(wr_addr_o), 33'(0));
        @(posedge clk);
        #1;
        chk("t1_count", 33'(count_o), 33'(1));

        // Back-to-back stream.
        c0 = send_cycles;
        send(ADD, 3, 1, 2, 0);
        send(SW, 0, 1, 2, 8);
        send(BEQ, 0, 1, 2, -4);
        send(JAL, 1, 0, 0, 2048);
        send(LUI, 5, 0, 0, 'h12345000);
        chk("t2_b2b_cycles", 33'(send_cycles - c0), 33'(5));
        @(negedge clk);
        chk("t2_last", 33'(wr_data_o), 33'(32'h123452B7));
        chk("t2_addr", 33'(wr_addr_o), 33'(5));
        idle(2);

        // Full: further requests stall until clear.
        chk("t4_full", 33'(full_o), 33'(1));
        chk("t4_count", 33'(count_o), 33'(DP));
        set_req(ORI, 4, 4, 0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall", 33'(req_ready_o), 33'(0));
        end
        @(posedge clk);
        #1;
        pulse_clear();
        chk("t4_clr_count", 33'(count_o), 33'(0));
        send(ORI, 4, 4, 0, 1);
        @(negedge clk);
        chk("t4_after_addr", 33'(wr_addr_o), 33'(0));
        idle(2);

        // IMEM backpressure.
        send(ADD, 3, 1, 2, 0);
        wr_ready_i = 1'b0;
        set_req(SW, 0, 1, 2, 8);
        repeat (3) begin
            @(negedge clk);
            chk("t3_ready", 33'(req_ready_o), 33'(0));
            chk("t3_hold", 33'(wr_data_o), 33'(32'h002081B3));
            @(posedge clk);
            #1;
        end
        wr_ready_i = 1'b1;
        send(SW, 0, 1, 2, 8);
        @(negedge clk);
        chk("t3_next", 33'(wr_data_o), 33'(32'h0020A423));
        idle(2);

        // Illegal requests.
        pulse_clear();
        send(ADDI, 1, 0, 0, 2048);
        @(negedge clk);
        chk("t5_nowr", 33'(wr_valid_o), 33'(0));
        chk("t5_err", 33'(err_o), 33'(1));
        send(BEQ, 0, 1, 2, 3);
        idle(3);
        chk("t5_err_hold", 33'(err_o), 33'(1));
        chk("t5_count", 33'(count_o), 33'(0));
        send(ADDI, 1, 0, 0, 5);
        @(negedge clk);
        chk("t5_addr", 33'(wr_addr_o), 33'(0));
        idle(2);
        pulse_clear();
        chk("t5_err_clr", 33'(err_o), 33'(0));

        // Boundary table; model checks every result.
        for (int i = 0; i < 22; i++) begin
            if (i % 4 == 0) begin
                idle(2);
                pulse_clear();
            end
            send(vm[i], 5, 6, 7, vi[i]);
        end
        idle(2);
        pulse_clear();

        // MUL.
        send(MUL, 3, 1, 2, 0);
        @(negedge clk);
`ifdef RV32I_ENC_RV32M_EN
        chk("t6_mul", 33'(wr_data_o), 33'(32'h022081B3));
`else
        chk("t6_mul_err", 33'(err_o), 33'(1));
        chk("t6_mul_nowr", 33'(wr_valid_o), 33'(0));
`endif
        idle(2);

        // Reset during a stalled write.
        pulse_clear();
        wr_ready_i = 1'b0;
        send(XORI, 2, 3, 0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 33'(wr_valid_o), 33'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_ready_i = 1'b1;
        idle(3);
        chk("rst_mid_count", 33'(count_o), 33'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
